// File: rtl/control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// ALU operation encodings and the dispatch codes produced by the encoder.
package control_pkg;

  typedef enum logic [6:0] {
    S_RESET       = 7'd0,
    S_FETCH_ADDR  = 7'd1,
    S_PC_INC      = 7'd2,
    S_FETCH_WAIT  = 7'd3,
    S_DECODE      = 7'd4,
    S_ADDU        = 7'd6,
    S_STORE_ADDR  = 7'd7,
    S_STORE_DATA  = 7'd8,
    S_STORE_WAIT  = 7'd9,
    S_BEQ_CMP     = 7'd11,
    S_BEQ_TAKE    = 7'd12,
    S_LOAD_ADDR   = 7'd13,
    S_LOAD_WAIT   = 7'd14,
    S_LOAD_WB     = 7'd15,
    S_SUBU        = 7'd17,
    S_MEM_ERR     = 7'd31
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Dispatch codes emitted by the instruction encoder; 0 means unsupported.
  localparam logic [6:0] DISPATCH_NONE  = 7'd0;
  localparam logic [6:0] DISPATCH_ADDU  = 7'd6;
  localparam logic [6:0] DISPATCH_STORE = 7'd7;
  localparam logic [6:0] DISPATCH_BEQ   = 7'd11;
  localparam logic [6:0] DISPATCH_LOAD  = 7'd13;
  localparam logic [6:0] DISPATCH_SUBU  = 7'd17;

  // True when the encoder code names an instruction this unit executes.
  function automatic logic is_dispatch(input logic [6:0] code);
    logic ok;
    case (code)
      DISPATCH_ADDU, DISPATCH_STORE, DISPATCH_BEQ,
      DISPATCH_LOAD, DISPATCH_SUBU: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the states that wait on the memory handshake.
  function automatic logic is_wait_state(input state_t s);
    logic w;
    case (s)
      S_FETCH_WAIT, S_STORE_WAIT, S_LOAD_WAIT: w = 1'b1;
      default:                                 w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory handshake states. Cleared on entry to a
// wait state, counts cycles without moc, and flags the final allowed cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              LIMIT   = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Wait counter: reset/clear to zero, saturating increment while enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  // A zero timeout disables expiry entirely.
  assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT_C);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control unit for the MIPS datapath: fetch/decode loop,
// instruction dispatch, datapath strobes and memory handshake with timeout.
module control_sequencer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] state_sel,
  input  logic       moc,
  input  logic       cond,
  output logic [6:0] state,
  output logic       mov,
  output logic       rw,
  output logic       mar_ld,
  output logic       mdr_ld,
  output logic       ir_ld,
  output logic       pc_ld,
  output logic       pc_src,
  output logic       rf_ld,
  output logic [1:0] alu_op,
  output logic       mem_err
);

  state_t state_q;
  state_t state_nxt;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_expired;

  // The counter restarts whenever a wait state is entered from elsewhere,
  // and advances only while waiting without a completion.
  assign timer_clear = is_wait_state(state_nxt) && (state_nxt != state_q);
  assign timer_en    = is_wait_state(state_q) && !moc;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; moc on the last allowed wait cycle beats the timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RESET:      state_nxt = S_FETCH_ADDR;
      S_FETCH_ADDR: state_nxt = S_PC_INC;
      S_PC_INC:     state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (moc) begin
          state_nxt = S_DECODE;
        end else if (timer_expired) begin
          state_nxt = S_MEM_ERR;
        end else begin
          state_nxt = S_FETCH_WAIT;
        end
      end
      S_DECODE: begin
        if (is_dispatch(state_sel)) begin
          state_nxt = state_t'(state_sel);
        end else begin
          state_nxt = S_FETCH_ADDR;
        end
      end
      S_ADDU:       state_nxt = S_FETCH_ADDR;
      S_SUBU:       state_nxt = S_FETCH_ADDR;
      S_STORE_ADDR: state_nxt = S_STORE_DATA;
      S_STORE_DATA: state_nxt = S_STORE_WAIT;
      S_STORE_WAIT: begin
        if (moc) begin
          state_nxt = S_FETCH_ADDR;
        end else if (timer_expired) begin
          state_nxt = S_MEM_ERR;
        end else begin
          state_nxt = S_STORE_WAIT;
        end
      end
      S_BEQ_CMP: begin
        if (cond) begin
          state_nxt = S_BEQ_TAKE;
        end else begin
          state_nxt = S_FETCH_ADDR;
        end
      end
      S_BEQ_TAKE:   state_nxt = S_FETCH_ADDR;
      S_LOAD_ADDR:  state_nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (moc) begin
          state_nxt = S_LOAD_WB;
        end else if (timer_expired) begin
          state_nxt = S_MEM_ERR;
        end else begin
          state_nxt = S_LOAD_WAIT;
        end
      end
      S_LOAD_WB:    state_nxt = S_FETCH_ADDR;
      S_MEM_ERR:    state_nxt = S_MEM_ERR;
      default:      state_nxt = S_RESET;
    endcase
  end

  // Output decode: Moore from state, except ir_ld/mdr_ld in the moc cycle.
  always_comb begin
    mov     = 1'b0;
    rw      = 1'b0;
    mar_ld  = 1'b0;
    mdr_ld  = 1'b0;
    ir_ld   = 1'b0;
    pc_ld   = 1'b0;
    pc_src  = 1'b0;
    rf_ld   = 1'b0;
    alu_op  = ALU_ADD;
    mem_err = 1'b0;
    case (state_q)
      S_FETCH_ADDR: mar_ld = 1'b1;
      S_PC_INC: begin
        pc_ld  = 1'b1;
        pc_src = 1'b0;
      end
      S_FETCH_WAIT: begin
        mov   = 1'b1;
        rw    = 1'b1;
        ir_ld = moc;
      end
      S_ADDU: begin
        alu_op = ALU_ADD;
        rf_ld  = 1'b1;
      end
      S_SUBU: begin
        alu_op = ALU_SUB;
        rf_ld  = 1'b1;
      end
      S_STORE_ADDR: begin
        alu_op = ALU_ADD;
        mar_ld = 1'b1;
      end
      S_STORE_DATA: mdr_ld = 1'b1;
      S_STORE_WAIT: begin
        mov = 1'b1;
        rw  = 1'b0;
      end
      S_BEQ_CMP:    alu_op = ALU_SUB;
      S_BEQ_TAKE: begin
        pc_ld  = 1'b1;
        pc_src = 1'b1;
      end
      S_LOAD_ADDR: begin
        alu_op = ALU_ADD;
        mar_ld = 1'b1;
      end
      S_LOAD_WAIT: begin
        mov    = 1'b1;
        rw     = 1'b1;
        mdr_ld = moc;
      end
      S_LOAD_WB:    rf_ld   = 1'b1;
      S_MEM_ERR:    mem_err = 1'b1;
      default: begin
        mov = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multicycle control unit for the MIPS datapath. Holds the current control state, runs the fetch/decode loop, and dispatches on the 7-bit state code from the instruction encoder (ADDU=6, SUBU=17, stores=7, BEQ=11, loads=13, 0 when unsupported). Drives the datapath register-load strobes and the ALU op. Owns the memory handshake (mov/moc) and enforces a timeout on every memory wait.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in one memory-wait state before error; 0 disables the timeout.
CNT_W, 8, width of the wait counter; MEM_TIMEOUT must be below 2^CNT_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
state_sel  in  7  dispatch code from the instruction encoder (valid in DECODE)
moc  in  1  memory operation complete
cond  in  1  ALU zero flag, branch condition
state  out  7  current state code
mov  out  1  memory operation valid
rw  out  1  1=read, 0=write (meaningful only while mov=1)
mar_ld  out  1  load MAR
mdr_ld  out  1  load MDR
ir_ld  out  1  load IR
pc_ld  out  1  load PC
pc_src  out  1  0=PC+4, 1=branch target
rf_ld  out  1  register-file write enable
alu_op  out  2  00=ADD, 01=SUB, others reserved
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- State register resets to S0. All strobes, mov, rw, pc_src, alu_op and mem_err are 0 in S0. The wait counter is 0.
- Outputs are Moore, decoded from state. The exceptions are ir_ld and mdr_ld: these are Mealy and assert only in the wait cycle where moc=1.
- S0 RESET -> S1.
- S1 FETCH_ADDR: mar_ld=1. -> S2.
- S2 PC_INC: pc_ld=1, pc_src=0. -> S3.
- S3 FETCH_WAIT: mov=1, rw=1. If moc: ir_ld=1, -> S4. Otherwise stay.
- S4 DECODE: next = state_sel when it is 6, 7, 11, 13 or 17. Any other value (including 0) -> S1, executed as a NOP.
- S6 ADDU: alu_op=ADD, rf_ld=1. -> S1.
- S17 SUBU: alu_op=SUB, rf_ld=1. -> S1.
- S7 STORE_ADDR: alu_op=ADD, mar_ld=1. -> S8.
- S8 STORE_DATA: mdr_ld=1. -> S9.
- S9 STORE_WAIT: mov=1, rw=0. On moc -> S1.
- S11 BEQ_CMP: alu_op=SUB. If cond -> S12, else -> S1.
- S12 BEQ_TAKE: pc_ld=1, pc_src=1. -> S1.
- S13 LOAD_ADDR: alu_op=ADD, mar_ld=1. -> S14.
- S14 LOAD_WAIT: mov=1, rw=1. On moc: mdr_ld=1, -> S15.
- S15 LOAD_WB: rf_ld=1. -> S1.
- S31 MEM_ERR: mem_err=1. mov=0 and all strobes are 0. The FSM stays here until reset.
- Wait counter (applies to S3, S9, S14):
  - Cleared on any transition into a wait state.
  - Increments each cycle the FSM stays in the wait state without moc.
  - If MEM_TIMEOUT!=0, moc=0 and counter==MEM_TIMEOUT-1, next state is S31.
  - moc arriving in that same cycle wins: normal transition, no error.
- moc outside a wait state is ignored.
- mov stays asserted continuously for the whole wait. rw is stable for the whole wait.
- reset in any state, including mid-wait and S31, forces S0 on the next edge and clears mem_err and the counter.
- Instruction latency with moc on the first wait cycle:
  - ADDU/SUBU: 5 cycles.
  - BEQ not taken: 5 cycles; taken: 6.
  - Load: 7 cycles.
  - Store: 7 cycles.
  - Each cycle moc is late adds one cycle.

Decomposition:
- Shared package control_pkg holds:
  - the state-code localparams (S_RESET=0 ... S_MEM_ERR=31);
  - the alu_op encodings;
  - dispatch codes matching the encoder (6, 7, 11, 13, 17).
- The encoder must import these so the codes cannot diverge.
- One sub-module, mem_wait_timer: counter with clear/enable inputs and an expired output.
- All else lives in one next-state block and one output-decode block.

Test Plan:
1. reset=1 for 2 cycles, then release, moc=0: state goes 0 -> 1 -> 2 -> 3, then holds in 3 with mov=1, rw=1. mem_err=0 through cycle 17. state=31 with mem_err=1 after 16 wait cycles (MEM_TIMEOUT=16).
2. ADDU fetch with moc on the first S3 cycle, state_sel=6: sequence 1, 2, 3, 4, 6, 1. ir_ld pulses once in S3 and rf_ld once in S6 with alu_op=00.
3. BEQ with state_sel=11: cond=1 gives 11 -> 12 (pc_ld=1, pc_src=1) -> 1. cond=0 gives 11 -> 1 and pc_ld stays 0.
4. LW with state_sel=13 and moc delayed 3 cycles in S14: mov=1 for 4 cycles, mdr_ld=1 only in the moc cycle, then 15 (rf_ld=1) -> 1.
5. SW with state_sel=7: 7 (mar_ld) -> 8 (mdr_ld) -> 9 (mov=1, rw=0) -> 1 on moc. rf_ld is never asserted.
6. Edge cases:
   - moc on the 16th cycle of S9 (counter=15): the FSM goes to S1, not S31.
   - state_sel=0 in S4: the FSM goes to S1.
   - reset asserted in S14: state=0 next cycle, all outputs 0.
